// File: rtl/iterative_divider_pkg.sv
// Shared constants and types for the iterative LEGv8 SDIV/UDIV divider.
package iterative_divider_pkg;

  localparam int unsigned DIV_WORD  = 64;
  localparam int unsigned DIV_CNT_W = 7;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // Sign/zero facts captured at launch and consumed in the fix-up cycle.
  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic dz;
  } div_flags_t;

endpackage

// File: rtl/iterative_divider_div_step.sv
// One radix-2 restoring division iteration (combinational).
module div_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_q
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub_lo;
  logic             take;

  // Partial remainder stays below the divisor, so the low WIDTH bits of the
  // difference are exact whenever the trial subtraction is non-negative.
  always_comb begin
    shifted  = {rem, q[WIDTH-1]};
    take     = (shifted >= {1'b0, dvs});
    sub_lo   = shifted[WIDTH-1:0] - dvs;
    next_rem = take ? sub_lo : shifted[WIDTH-1:0];
    next_q   = {q[WIDTH-2:0], take};
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle signed/unsigned integer divider with a level start/done handshake.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WORD,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  div_flags_t       flags_q, flags_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic             done_d, busy_d;
  logic [WIDTH-1:0] step_rem, step_q;
  logic             dvd_neg, dvs_neg;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .q       (q_q),
    .dvs     (dvs_q),
    .next_rem(step_rem),
    .next_q  (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      flags_q   <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      flags_q   <= flags_d;
      quotient  <= quotient_d;
      remainder <= remainder_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    flags_d     = flags_q;
    quotient_d  = quotient;
    remainder_d = remainder;
    dvd_neg     = div_mode & dividend[WIDTH-1];
    dvs_neg     = div_mode & divisor[WIDTH-1];

    unique case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d       = DIV_RUN;
          // Signed MIN keeps its bit pattern, which is the correct unsigned magnitude.
          q_d           = dvd_neg ? (-dividend) : dividend;
          dvs_d         = dvs_neg ? (-divisor) : divisor;
          dvd_d         = dividend;
          flags_d.neg_q = dvd_neg ^ dvs_neg;
          flags_d.neg_r = dvd_neg;
          flags_d.dz    = (divisor == '0);
          rem_d         = '0;
          cnt_d         = '0;
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        // Divide-by-zero follows ARM: quotient 0, remainder is the dividend.
        if (flags_q.dz) begin
          quotient_d  = '0;
          remainder_d = dvd_q;
        end else begin
          quotient_d  = flags_q.neg_q ? (-q_q) : q_q;
          remainder_d = flags_q.neg_r ? (-rem_q) : rem_q;
        end
        state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (!start) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    done_d = (state_q == DIV_DONE);
    busy_d = (state_q == DIV_RUN) || (state_q == DIV_FIX);
  end

endmodule
